// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounce, synchronise, auto-repeat and arbitrate seven push-buttons
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 20000000,
    parameter logic [4:0]  REPEAT_EN       = 5'b01111,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnR,
    input  logic       BtnL,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnC,
    input  logic       BtnStart,
    input  logic       BtnAck,
    output logic       Right,
    output logic       Left,
    output logic       Up,
    output logic       Down,
    output logic       Select,
    output logic       Start,
    output logic       Ack,
    output logic       StartDB,
    output logic       AckDB,
    output logic [4:0] Pending
);

    // Channel index: 0 Right, 1 Left, 2 Up, 3 Down, 4 Select, 5 Start, 6 Ack.
    localparam int NCH = 7;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [NCH-1:0]   REP_MASK   = {2'b00, REPEAT_EN};

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PULSE,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync_a;
    logic [NCH-1:0] sync_b;
    logic [NCH-1:0] req;
    logic [1:0]     level;

    assign raw = {BtnAck, BtnStart, BtnC, BtnD, BtnU, BtnL, BtnR};

    // Two-flop synchroniser for every raw button
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        localparam logic REP = REP_MASK[ch];

        state_t           state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic             first, first_nx;
        logic             req_ch;

        // Channel state, counter and first-repeat flag
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                state <= IDLE;
                cnt   <= '0;
                first <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                first <= first_nx;
            end
        end

        // Debounce / hold / repeat sequencing; a release glitch returns to HELD silently
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            first_nx = first;
            req_ch   = 1'b0;
            case (state)
                IDLE: begin
                    if (sync_b[ch]) begin
                        state_nx = PRESS_WAIT;
                        cnt_nx   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_b[ch]) begin
                        state_nx = IDLE;
                    end else if (cnt == DB_LAST) begin
                        state_nx = PULSE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                PULSE: begin
                    req_ch   = 1'b1;
                    state_nx = HELD;
                    cnt_nx   = '0;
                    first_nx = 1'b1;
                end
                HELD: begin
                    if (!sync_b[ch]) begin
                        state_nx = RELEASE_WAIT;
                        cnt_nx   = '0;
                    end else if (REP && (cnt == (first ? RPT_FIRST : RPT_NEXT))) begin
                        req_ch   = 1'b1;
                        cnt_nx   = '0;
                        first_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_b[ch]) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end else if (cnt == DB_LAST) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        assign req[ch] = req_ch;

        if (ch >= 5) begin : g_level
            assign level[ch-5] = (state == PULSE) || (state == HELD) || (state == RELEASE_WAIT);
        end
    end

    // Start/Ack bypass the arbiter: pulse and debounced level registered directly
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Start   <= 1'b0;
            Ack     <= 1'b0;
            StartDB <= 1'b0;
            AckDB   <= 1'b0;
        end else begin
            Start   <= req[5];
            Ack     <= req[6];
            StartDB <= level[0];
            AckDB   <= level[1];
        end
    end

    logic [4:0] grant;
    logic [4:0] pending_nx;

    // Lowest set bit wins (Right highest); a request landing on the serviced bit re-arms it
    always_comb begin
        grant      = Pending & (~Pending + 5'd1);
        pending_nx = (Pending & ~grant) | req[4:0];
    end

    // Pending set and registered one-hot game-key pulses
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Pending <= '0;
            {Select, Down, Up, Left, Right} <= '0;
        end else begin
            Pending <= pending_nx;
            {Select, Down, Up, Left, Right} <= grant;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized scoreboard bench for button_conditioner
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam logic [4:0] REN = 5'b01111;

    logic Clk, Reset;
    logic BtnR, BtnL, BtnU, BtnD, BtnC, BtnStart, BtnAck;
    logic Right, Left, Up, Down, Select, Start, Ack, StartDB, AckDB;
    logic [4:0] Pending;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .REPEAT_EN(REN), .CNT_W(8)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .BtnR(BtnR), .BtnL(BtnL), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
        .BtnStart(BtnStart), .BtnAck(BtnAck),
        .Right(Right), .Left(Left), .Up(Up), .Down(Down), .Select(Select),
        .Start(Start), .Ack(Ack), .StartDB(StartDB), .AckDB(AckDB),
        .Pending(Pending)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Reference model: a level change is accepted after D+1 consecutive samples of the
    // new level; repeats are scheduled as absolute edge numbers.
    typedef struct { int cyc; logic [6:0] v; } ev_t;
    ev_t exp_q[$];

    int   ecnt = 0;
    int   mode[7];      // 0 released, 1 just accepted, 2 held, 3 maybe releasing
    int   run[7];
    int   due[7];
    bit   first_m[7];
    bit   d1[7], d2[7];
    bit   req_m[7];
    bit   pend[5];
    logic [6:0] outv;
    logic [6:0] raw_m;
    logic [4:0] exp_pend = '0;
    logic [1:0] exp_db = '0;

    assign raw_m = {BtnAck, BtnStart, BtnC, BtnD, BtnU, BtnL, BtnR};

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int c = 0; c < 7; c++) begin
                mode[c] = 0; run[c] = 0; due[c] = 0; first_m[c] = 0; d1[c] = 0; d2[c] = 0;
            end
            for (int k = 0; k < 5; k++) pend[k] = 0;
            exp_q.delete();
            exp_pend = '0;
            exp_db   = '0;
        end else begin
            ecnt++;
            outv   = '0;
            exp_db = {mode[6] != 0, mode[5] != 0};
            for (int c = 0; c < 7; c++) begin
                bit s;
                s = d2[c];
                req_m[c] = 0;
                case (mode[c])
                    0: if (s) begin
                           run[c]++;
                           if (run[c] == D + 1) begin mode[c] = 1; run[c] = 0; end
                       end else run[c] = 0;
                    1: begin req_m[c] = 1; mode[c] = 2; due[c] = ecnt + RD; first_m[c] = 1; end
                    2: if (!s) begin mode[c] = 3; run[c] = 1; end
                       else if (c < 5 && REN[c] && ecnt == due[c]) begin
                           req_m[c] = 1; first_m[c] = 0; due[c] = ecnt + RP;
                       end
                    default: if (s) begin
                           mode[c] = 2; run[c] = 0; due[c] = ecnt + (first_m[c] ? RD : RP);
                       end else begin
                           run[c]++;
                           if (run[c] == D + 1) begin mode[c] = 0; run[c] = 0; end
                       end
                endcase
                d2[c] = d1[c];
                d1[c] = raw_m[c];
            end
            for (int k = 0; k < 5; k++)
                if (pend[k]) begin outv[k] = 1'b1; pend[k] = 0; break; end
            for (int k = 0; k < 5; k++) if (req_m[k]) pend[k] = 1;
            outv[5] = req_m[5];
            outv[6] = req_m[6];
            for (int k = 0; k < 5; k++) exp_pend[k] = pend[k];
            if (outv != '0) exp_q.push_back('{ecnt, outv});
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows a pulse
    int pq[7][$];
    int db_rise = -1;
    logic [4:0] pend_any = '0;
    logic [6:0] mon_v;

    always @(posedge Clk) begin
        #2;
        mon_v = {Ack, Start, Select, Down, Up, Left, Right};
        while (exp_q.size() > 0 && exp_q[0].cyc < ecnt) begin
            check("sb_missing", 32'(0), 32'(exp_q[0].v));
            void'(exp_q.pop_front());
        end
        if (mon_v != '0) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != ecnt) begin
                check("sb_unexpected", 32'(mon_v), 32'(0));
            end else begin
                check("sb_pulse", 32'(mon_v), 32'(exp_q[0].v));
                void'(exp_q.pop_front());
            end
        end
        check("pending", 32'(Pending), 32'(exp_pend));
        check("db_level", 32'({AckDB, StartDB}), 32'(exp_db));
        check("mutex", 32'($countones(mon_v[4:0]) <= 1), 32'(1));
        for (int k = 0; k < 7; k++) if (mon_v[k]) pq[k].push_back(ecnt);
        if (StartDB && db_rise < 0) db_rise = ecnt;
        pend_any |= Pending;
    end

    function automatic int qat(input int k, input int i, input int base);
        if (pq[k].size() > i) return pq[k][i] - base;
        return -1000;
    endfunction

    task automatic clear_stats();
        for (int k = 0; k < 7; k++) pq[k].delete();
        db_rise  = -1;
        pend_any = '0;
    endtask

    task automatic set_raw(input logic [6:0] v);
        {BtnAck, BtnStart, BtnC, BtnD, BtnU, BtnL, BtnR} = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    int e0;
    int up_exp[6] = '{8, 18, 23, 28, 33, 38};
    logic [6:0] base_v, glitch;

    initial begin
        Reset = 1'b0;
        set_raw('0);
        idle(3);
        check("reset_outs", 32'({Right, Left, Up, Down, Select, Start, Ack, StartDB, AckDB}), 32'(0));
        check("reset_pending", 32'(Pending), 32'(0));
        Reset = 1'b1;
        idle(3);

        // Clean press on Right, held 20 cycles (one repeat falls inside)
        clear_stats(); e0 = ecnt + 1;
        BtnR = 1'b1; idle(20); BtnR = 1'b0; idle(20);
        check("right_first", 32'(qat(0, 0, e0)), 32'(8));
        check("right_repeat", 32'(qat(0, 1, e0)), 32'(18));
        check("right_only", 32'(pq[1].size() + pq[2].size() + pq[3].size() + pq[4].size()), 32'(0));

        // Start press, 8 cycles
        clear_stats(); e0 = ecnt + 1;
        BtnStart = 1'b1; idle(8); BtnStart = 1'b0; idle(20);
        check("start_count", 32'(pq[5].size()), 32'(1));
        check("start_at", 32'(qat(5, 0, e0)), 32'(7));
        check("startdb_rise", 32'(db_rise - e0), 32'(7));

        // Bounce rejection then a steady press
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            BtnL = ((i % 4) != 3);
            idle(1);
        end
        BtnL = 1'b0; idle(10);
        check("bounce_left", 32'(pq[1].size()), 32'(0));
        check("bounce_pending", 32'(pend_any), 32'(0));
        BtnL = 1'b1; idle(10); BtnL = 1'b0; idle(20);
        check("steady_left", 32'(pq[1].size()), 32'(1));

        // Auto-repeat on Up
        clear_stats(); e0 = ecnt + 1;
        BtnU = 1'b1; idle(40); BtnU = 1'b0; idle(20);
        check("up_count", 32'(pq[2].size()), 32'(6));
        for (int i = 0; i < 6; i++) check("up_edge", 32'(qat(2, i, e0)), 32'(up_exp[i]));

        // Select and Ack never repeat
        clear_stats();
        BtnC = 1'b1; idle(40); BtnC = 1'b0; idle(20);
        BtnAck = 1'b1; idle(40); BtnAck = 1'b0; idle(20);
        check("select_once", 32'(pq[4].size()), 32'(1));
        check("ack_once", 32'(pq[6].size()), 32'(1));

        // Arbitration of simultaneous Right, Down, Select
        clear_stats(); e0 = ecnt + 1;
        BtnR = 1'b1; BtnD = 1'b1; BtnC = 1'b1;
        idle(8);
        check("arb_pend7", 32'(Pending), 32'(5'b11001));
        idle(1);
        check("arb_pend8", 32'(Pending), 32'(5'b11000));
        check("arb_right8", 32'({Right, Down, Select}), 32'(3'b100));
        idle(1);
        check("arb_pend9", 32'(Pending), 32'(5'b10000));
        check("arb_down9", 32'({Right, Down, Select}), 32'(3'b010));
        idle(1);
        check("arb_pend10", 32'(Pending), 32'(5'b00000));
        check("arb_sel10", 32'({Right, Down, Select}), 32'(3'b001));
        idle(1);
        BtnR = 1'b0; BtnD = 1'b0; BtnC = 1'b0; idle(20);

        // Release glitch on Down: glitch restarts the repeat timer, no pulse of its own
        clear_stats(); e0 = ecnt + 1;
        BtnD = 1'b1; idle(12); BtnD = 1'b0; idle(2); BtnD = 1'b1; idle(16); BtnD = 1'b0; idle(20);
        check("glitch_count", 32'(pq[3].size()), 32'(3));
        check("glitch_p0", 32'(qat(3, 0, e0)), 32'(8));
        check("glitch_p1", 32'(qat(3, 1, e0)), 32'(27));
        check("glitch_p2", 32'(qat(3, 2, e0)), 32'(32));

        // Reset in the middle of a Right press, button still held afterwards
        clear_stats();
        BtnR = 1'b1; idle(6);
        Reset = 1'b0; #1;
        check("rst_async_outs", 32'({Right, Left, Up, Down, Select, Start, Ack, StartDB, AckDB}), 32'(0));
        check("rst_async_pend", 32'(Pending), 32'(0));
        idle(2);
        clear_stats();
        Reset = 1'b1; e0 = ecnt + 1;
        idle(12); BtnR = 1'b0; idle(20);
        check("rst_right_count", 32'(pq[0].size()), 32'(1));
        check("rst_right_at", 32'(qat(0, 0, e0)), 32'(8));

        // Randomised traffic with glitches, contention and occasional resets
        base_v = '0;
        for (int i = 0; i < 3000; i++) begin
            glitch = '0;
            for (int c = 0; c < 7; c++) begin
                if ($urandom_range(0, 99) < 4) base_v[c] = ~base_v[c];
                if ($urandom_range(0, 99) < 2) glitch[c] = 1'b1;
            end
            set_raw(base_v ^ glitch);
            if ($urandom_range(0, 999) == 0) begin
                Reset = 1'b0; idle(2); Reset = 1'b1;
            end
            idle(1);
        end
        set_raw('0);
        idle(40);
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
